// File: rtl/seq_det_event_counter_if.sv
// -----------------------------------------------------------------------------
// seq_det_event_counter_if
//   Report port of the detection-event window counter.
//
//   Handshake: the producer raises rep_valid when a report is held and keeps
//   rep_valid, rep_count and rep_sat stable until a rising clock edge where
//   rep_valid & rep_ready are both 1; that edge is the transfer. rep_ready may
//   be driven at any time and does not depend on rep_valid. rep_overrun is a
//   status flag outside the handshake.
//
//   Signals
//     rep_valid    producer -> consumer  report holding register is full
//     rep_ready    consumer -> producer  consumer accepts the report
//     rep_count    producer -> consumer  event count of the last closed window
//     rep_sat      producer -> consumer  that window's count saturated
//     rep_overrun  producer -> consumer  sticky: an unconsumed report was lost
//
//   Modports
//     master  the counter (drives the report)
//     slave   the report consumer
// -----------------------------------------------------------------------------
interface seq_det_event_counter_if #(
  parameter int CNT_W = 8
);
  logic             rep_valid;
  logic             rep_ready;
  logic [CNT_W-1:0] rep_count;
  logic             rep_sat;
  logic             rep_overrun;

  modport master (
    output rep_valid,
    output rep_count,
    output rep_sat,
    output rep_overrun,
    input  rep_ready
  );

  modport slave (
    input  rep_valid,
    input  rep_count,
    input  rep_sat,
    input  rep_overrun,
    output rep_ready
  );
endinterface

// File: rtl/seq_det_event_counter.sv
// -----------------------------------------------------------------------------
// seq_det_event_counter
//   Counts rising edges of the 110-pattern detector output over fixed windows
//   of WINDOW clocks and offers each closed window's count on a valid/ready
//   report port. Also produces a per-event strobe and sticky
//   saturation/overrun status.
//
//   Parameters
//     CNT_W   event counter / report width; saturates at 2**CNT_W-1
//     WINDOW  window length in clk cycles (>= 2)
//
//   Ports
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     enable     in   1 = count windows (RUN), 0 = IDLE
//     clr        in   synchronous clear of counters, report and status
//     det_in     in   detector output, stable at posedge clk
//     det_pulse  out  1-cycle strobe for each event seen while running
//     rep        if   report port (master side): rep_valid, rep_ready,
//                     rep_count, rep_sat, rep_overrun
//     dbg_state  out  1 when the FSM is in RUN
// -----------------------------------------------------------------------------
module seq_det_event_counter #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           clr,
  input  logic                           det_in,
  output logic                           det_pulse,
  seq_det_event_counter_if.master        rep,
  output logic                           dbg_state
);

  localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q,      state_d;
  logic [WIN_W-1:0]   win_cnt_q,    win_cnt_d;
  logic [CNT_W-1:0]   ev_cnt_q,     ev_cnt_d;
  logic               sat_q,        sat_d;
  logic               det_prev_q;
  logic               det_pulse_q,  det_pulse_d;
  logic               rep_valid_q,  rep_valid_d;
  logic [CNT_W-1:0]   rep_count_q,  rep_count_d;
  logic               rep_sat_q,    rep_sat_d;
  logic               rep_overrun_q, rep_overrun_d;

  logic               ev;
  logic               at_max;

  // A held-high det_in is a single event: only the 0->1 transition counts.
  assign ev     = det_in & ~det_prev_q;
  assign at_max = (ev_cnt_q == CNT_MAX);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      win_cnt_q     <= '0;
      ev_cnt_q      <= '0;
      sat_q         <= 1'b0;
      det_prev_q    <= 1'b0;
      det_pulse_q   <= 1'b0;
      rep_valid_q   <= 1'b0;
      rep_count_q   <= '0;
      rep_sat_q     <= 1'b0;
      rep_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_cnt_q     <= win_cnt_d;
      ev_cnt_q      <= ev_cnt_d;
      sat_q         <= sat_d;
      det_prev_q    <= det_in;
      det_pulse_q   <= det_pulse_d;
      rep_valid_q   <= rep_valid_d;
      rep_count_q   <= rep_count_d;
      rep_sat_q     <= rep_sat_d;
      rep_overrun_q <= rep_overrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    win_cnt_d     = win_cnt_q;
    ev_cnt_d      = ev_cnt_q;
    sat_d         = sat_q;
    det_pulse_d   = ev & (state_q == RUN);
    rep_valid_d   = rep_valid_q;
    rep_count_d   = rep_count_q;
    rep_sat_d     = rep_sat_q;
    rep_overrun_d = rep_overrun_q;

    // Transfer of the held report; a window close below may refill it.
    if (rep_valid_q && rep.rep_ready) begin
      rep_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // Counters sit at zero so entering RUN starts a fresh window.
        win_cnt_d = '0;
        ev_cnt_d  = '0;
        sat_d     = 1'b0;
        if (enable) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (!enable) begin
          // Leaving mid-window: the partial window is discarded.
          state_d   = IDLE;
          win_cnt_d = '0;
          ev_cnt_d  = '0;
          sat_d     = 1'b0;
        end else if (win_cnt_q == WIN_LAST) begin
          // Window close. The event on this cycle belongs to this window.
          rep_count_d   = (ev && !at_max) ? ev_cnt_q + CNT_W'(1) : ev_cnt_q;
          rep_sat_d     = sat_q | (ev & at_max);
          // Overwriting a report the consumer has not taken this edge.
          rep_overrun_d = rep_overrun_q | (rep_valid_q & ~rep.rep_ready);
          rep_valid_d   = 1'b1;
          win_cnt_d     = '0;
          ev_cnt_d      = '0;
          sat_d         = 1'b0;
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
          if (ev) begin
            if (at_max) begin
              sat_d = 1'b1;
            end else begin
              ev_cnt_d = ev_cnt_q + CNT_W'(1);
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Clear overrides a same-cycle close and handshake; state still follows
    // enable so a running counter restarts its window at zero.
    if (clr) begin
      state_d       = enable ? RUN : IDLE;
      win_cnt_d     = '0;
      ev_cnt_d      = '0;
      sat_d         = 1'b0;
      rep_valid_d   = 1'b0;
      rep_overrun_d = 1'b0;
      det_pulse_d   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign det_pulse       = det_pulse_q;
  assign rep.rep_valid   = rep_valid_q;
  assign rep.rep_count   = rep_count_q;
  assign rep.rep_sat     = rep_sat_q;
  assign rep.rep_overrun = rep_overrun_q;
  assign dbg_state       = (state_q == RUN);

endmodule
